wb_uart_tx: RTL and testbench

- Wishbone B4 classic slave: a transmit-only UART with a byte FIFO, sitting on the same bus as mem, downstream of cpu_wb.
- Gives the CPU a serial output path.
- CPU writes bytes to a DATA register; the block serialises them as 8N1 on tx_o.
- A STATUS/CTRL register exposes FIFO state, a sticky overflow flag and an interrupt enable.

---
 rtl/wb_uart_tx_if.sv | 21 ++
 rtl/wb_uart_tx.sv | 142 ++++++++++++++
 tb/tb_wb_uart_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_tx_if.sv
// Wishbone B4 classic bus bundle for wb_uart_tx; signal names keep the original port names.
interface wb_uart_tx_if;
  logic [29:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        ack_o;
  logic [31:0] dat_o;

  modport master (
    output adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
    output ack_o, dat_o
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Transmit-only 8N1 UART behind a Wishbone classic slave port, with a byte FIFO,
// sticky overflow flag and a transmit-done interrupt.
module wb_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_uart_tx_if.slave  wb,
  output logic         tx_o,
  output logic         irq_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            tx_q, irq_q, ack_q, ovf_q, irq_en_q;
  logic [31:0]     dat_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            access, wr_data, wr_stat, rd_stat;
  logic            fifo_empty, fifo_full, busy, pop, push;
  logic [31:0]     status;
  logic            unused_bits;

  assign unused_bits = ^{wb.adr_i[29:1], wb.dat_i[31:8], wb.sel_i[3:1]};

  always_comb begin
    access     = wb.cyc_i & wb.stb_i & ~ack_q;
    wr_data    = access & wb.we_i & ~wb.adr_i[0] & wb.sel_i[0];
    wr_stat    = access & wb.we_i &  wb.adr_i[0] & wb.sel_i[0];
    rd_stat    = access & ~wb.we_i & wb.adr_i[0];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    busy       = (state_q != S_IDLE);
    pop        = ~busy & ~fifo_empty;
    // A pop on the same edge frees the slot a full-FIFO push needs.
    push       = wr_data & (~fifo_full | pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    ovf_d      = ovf_q;
    if (wr_stat && wb.dat_i[3]) ovf_d = 1'b0;
    if (wr_data && !push)       ovf_d = 1'b1;
    status        = '0;
    status[0]     = fifo_full;
    status[1]     = fifo_empty;
    status[2]     = busy;
    status[3]     = ovf_q;
    status[4]     = irq_en_q;
    status[15:8]  = 8'(count_q);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wb.dat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q   <= access;
      dat_q   <= rd_stat ? status : '0;
      irq_q   <= irq_en_q & fifo_empty & ~busy;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (wr_stat) irq_en_q <= wb.dat_i[4];
      if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);

      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            shreg_q <= mem[rd_ptr_q];
            tx_q    <= 1'b0;
            baud_q  <= BW'(CLK_DIV - 1);
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            baud_q  <= BW'(CLK_DIV - 1);
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BW'(CLK_DIV - 1);
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // Shift so the next bit is always at shreg_q[0].
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        S_STOP: begin
          if (baud_q == '0) begin
            baud_q  <= BW'(CLK_DIV - 1);
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.dat_o = dat_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: frame-timeline reference model checked every cycle,
// plus literal expectations scheduled at specific cycles.
module tb_wb_uart_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME      = 10 * CLK_DIV;

  localparam logic [34:0] M_ACK = 35'h4_0000_0000;
  localparam logic [34:0] M_IRQ = 35'h2_0000_0000;
  localparam logic [34:0] M_TX  = 35'h1_0000_0000;
  localparam logic [34:0] M_DAT = 35'h0_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic tx, irq;

  wb_uart_tx_if wbif ();

  wb_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wbif.slave),
    .tx_o  (tx),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, serial output from frame start time.
  int        cyc_n   = 0;
  bit        valid   = 0;
  bit        active  = 0;
  int        s_start = 0;
  bit [7:0]  q[$];
  bit [7:0]  sh      = '0;
  bit        ack_m   = 0, ovf_m = 0, irqen_m = 0, irq_m = 0, tx_m = 1;
  bit [31:0] dat_m   = '0;

  always @(posedge clk) begin
    bit        idle_b, acc;
    int        cnt_b, k, idx;
    bit [31:0] st;
    cyc_n++;
    if (rst) begin
      q.delete();
      active = 0; ack_m = 0; ovf_m = 0; irqen_m = 0; irq_m = 0; tx_m = 1; dat_m = '0;
      valid = 1;
    end else begin
      idle_b = !active || ((cyc_n - 1 - s_start) >= FRAME);
      cnt_b  = q.size();
      acc    = wbif.cyc_i && wbif.stb_i && !ack_m;
      st     = {16'h0, 8'(cnt_b), 3'b000, irqen_m, ovf_m, !idle_b,
                (cnt_b == 0), (cnt_b == FIFO_DEPTH)};
      irq_m  = irqen_m && (cnt_b == 0) && idle_b;
      dat_m  = (acc && !wbif.we_i && wbif.adr_i[0]) ? st : 32'h0;
      ack_m  = acc;
      if (idle_b && cnt_b > 0) begin
        sh      = q.pop_front();
        active  = 1;
        s_start = cyc_n;
      end
      if (acc && wbif.we_i && wbif.sel_i[0]) begin
        if (!wbif.adr_i[0]) begin
          if (q.size() < FIFO_DEPTH) q.push_back(wbif.dat_i[7:0]);
          else ovf_m = 1;
        end else begin
          irqen_m = wbif.dat_i[4];
          if (wbif.dat_i[3]) ovf_m = 0;
        end
      end
      k = cyc_n - s_start;
      if (active && k < FRAME) begin
        idx  = k / CLK_DIV;
        tx_m = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : sh[idx-1];
      end else begin
        tx_m = 1;
      end
    end
  end

  typedef struct {
    int          c;
    logic [34:0] m;
    logic [34:0] v;
    string       nm;
  } lit_t;
  lit_t lit_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin
    logic [34:0] obs, want;
    obs  = {wbif.ack_o, irq, tx, wbif.dat_o};
    want = {ack_m, irq_m, tx_m, dat_m};
    if (valid) begin
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL model cyc=%0d got=%h want=%h", cyc_n, obs, want);
      end
    end
    for (int i = 0; i < lit_q.size(); i++) begin
      if (lit_q[i].c == cyc_n) begin
        n_tests++;
        if (((obs ^ lit_q[i].v) & lit_q[i].m) !== 35'h0) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h want=%h mask=%h",
                   lit_q[i].nm, cyc_n, obs & lit_q[i].m, lit_q[i].v, lit_q[i].m);
        end
      end
    end
  end

  task automatic expect_at(input int c, input logic [34:0] m, input logic [34:0] v,
                           input string nm);
    lit_t e;
    e.c = c; e.m = m; e.v = v; e.nm = nm;
    lit_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc_n < c) @(negedge clk);
  endtask

  task automatic access(input logic w, input logic a, input logic [31:0] d,
                        input logic [3:0] s, input bit chk, input logic [31:0] xd,
                        input string nm, output int e);
    @(negedge clk);
    wbif.cyc_i = 1'b1;
    wbif.stb_i = 1'b1;
    wbif.we_i  = w;
    wbif.adr_i = {29'h0, a};
    wbif.dat_i = d;
    wbif.sel_i = s;
    e = cyc_n + 1;
    if (chk) expect_at(e, M_ACK | M_DAT, {3'b100, xd}, nm);
    @(negedge clk);
    wbif.cyc_i = 1'b0;
    wbif.stb_i = 1'b0;
    wbif.we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int         e, e0;
    logic [9:0] pat;
    rst = 1'b1;
    wbif.cyc_i = 1'b0; wbif.stb_i = 1'b0; wbif.we_i = 1'b0;
    wbif.adr_i = '0;   wbif.dat_i = '0;   wbif.sel_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_at(cyc_n + 1, M_ACK | M_IRQ | M_TX, M_TX, "reset_outputs");
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0002, "reset_status", e);

    // Single byte 0xA5: start, LSB-first data, stop.
    access(1'b1, 1'b0, 32'h0000_00A5, 4'hF, 1, 32'h0, "a5_write_ack", e);
    pat = {1'b1, 8'hA5, 1'b0};
    expect_at(e + 1, M_TX, 35'h0, "a5_start_latency");
    for (int k = 0; k < 10; k++)
      expect_at(e + 3 + CLK_DIV * k, M_TX, pat[k] ? M_TX : 35'h0, "a5_bit");
    expect_at(e + FRAME + 1, M_TX, M_TX, "a5_after_frame");
    wait_to(e + FRAME + 4);
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0002, "a5_status_idle", e);

    // DATA write without sel_i[0]: acked, nothing queued.
    access(1'b1, 1'b0, 32'h0000_0055, 4'b1110, 1, 32'h0, "bytesel_ack", e);
    expect_at(e + 2, M_TX, M_TX, "bytesel_tx_idle");
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0002, "bytesel_status", e);

    // Ten back-to-back bytes while the first is on the line.
    for (int i = 0; i < 10; i++) begin
      access(1'b1, 1'b0, 32'h10 + i, 4'h1, 0, 32'h0, "", e);
      if (i == 0) e0 = e;
    end
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_080D, "ovf_status", e);
    access(1'b1, 1'b1, 32'h0000_0008, 4'h1, 1, 32'h0, "ovf_clear_ack", e);
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0805, "ovf_cleared", e);
    wait_to(e0 + 9 * (FRAME + 1) + 10);
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0002, "drain_status", e);

    // Interrupt around a 0x00 frame.
    access(1'b1, 1'b1, 32'h0000_0010, 4'h1, 0, 32'h0, "", e);
    access(1'b1, 1'b0, 32'h0000_0000, 4'h1, 0, 32'h0, "", e);
    expect_at(e + 20, M_IRQ, 35'h0, "irq_low_mid_frame");
    expect_at(e + FRAME + 1, M_IRQ, 35'h0, "irq_low_at_idle_edge");
    expect_at(e + FRAME + 2, M_IRQ, M_IRQ, "irq_high_after_idle");
    wait_to(e + FRAME + 6);
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0012, "irq_status", e);

    // Reset during data bit 3 of the first of two queued frames.
    access(1'b1, 1'b0, 32'h0000_00FF, 4'h1, 0, 32'h0, "", e0);
    access(1'b1, 1'b0, 32'h0000_000F, 4'h1, 0, 32'h0, "", e);
    wait_to(e0 + 1 + 4 * CLK_DIV);
    expect_at(cyc_n + 1, M_TX | M_ACK | M_IRQ, M_TX, "midframe_reset_edge");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc_n + 30, M_TX, M_TX, "midframe_no_more_frames");
    wait_to(cyc_n + 60);
    access(1'b0, 1'b1, 32'h0, 4'hF, 1, 32'h0000_0002, "midframe_status", e);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
